// File: rtl/instr_fetch_pkg.sv
// Shared types and default sizes for the instruction fetch sequencer.
package instr_fetch_pkg;

  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_INSTR_W  = 32;
  localparam int DEF_PROG_LEN = 19;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/instr_fetch_out_reg.sv
// One-entry output register presenting a fetched instruction over valid/ready.
// A flush drops the entry; a load overwrites it. The fetch logic upstream
// never asserts both in the same cycle, so flush is given priority only as a
// safeguard.
module fetch_out_reg
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               flush,
  input  logic               ready,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc,
  output logic               valid,
  output logic               valid_next
);

  // Next occupancy: flush empties, load fills, a plain accept empties.
  always_comb begin
    valid_next = valid;
    if (flush) begin
      valid_next = 1'b0;
    end else if (load) begin
      valid_next = 1'b1;
    end else if (valid && ready) begin
      valid_next = 1'b0;
    end
  end

  // Register the entry; payload only changes on a load so it holds under backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else begin
      valid <= valid_next;
      if (load) begin
        instr <= instr_in;
        pc    <= pc_in;
      end
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch sequencer: walks pc over the loaded program in the ROM, issues one
// combinational ROM read per fetch, and buffers the result in a one-entry
// valid/ready output register. Supports branch redirects and end-of-program halt.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int PROG_LEN = DEF_PROG_LEN,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int INSTR_W  = DEF_INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [ADDR_W-1:0]  rom_address,
  output logic               rom_enable,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               done
);

  localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(PROG_LEN - 1);
  localparam logic [ADDR_W:0]   PROG_END = (ADDR_W + 1)'(PROG_LEN);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_nxt;
  logic              fetch;
  logic              flush;
  logic              valid_nxt;
  logic              done_nxt;
  logic              redirect_in_range;

  // A fetch needs room in the output register and yields to any redirect.
  assign fetch = (state == RUN) && (!out_valid || out_ready) && !redirect_valid;
  // Redirects are ignored while idle.
  assign flush = redirect_valid && (state != IDLE);
  assign redirect_in_range = ({1'b0, redirect_addr} < PROG_END);

  assign rom_enable  = fetch;
  assign rom_address = pc;

  // Next state and pc; redirect outranks start and fetch. The last fetch
  // leaves pc parked on the final address so it can never wrap.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    if (flush) begin
      pc_nxt    = redirect_addr;
      state_nxt = redirect_in_range ? RUN : DONE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt = RUN;
            pc_nxt    = '0;
          end
        end
        RUN: begin
          if (fetch) begin
            if (pc == LAST_PC) begin
              state_nxt = DONE;
            end else begin
              pc_nxt = pc + ADDR_W'(1);
            end
          end
        end
        DONE: begin
          if (start) begin
            state_nxt = RUN;
            pc_nxt    = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          pc_nxt    = '0;
        end
      endcase
    end
  end

  // done is registered from the next-cycle view so it rises right after the final accept.
  assign done_nxt = (state_nxt == DONE) && !valid_nxt;

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc    <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      done  <= done_nxt;
    end
  end

  fetch_out_reg #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_out_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (fetch),
    .flush      (flush),
    .ready      (out_ready),
    .instr_in   (rom_data),
    .pc_in      (pc),
    .instr      (out_instr),
    .pc         (out_pc),
    .valid      (out_valid),
    .valid_next (valid_nxt)
  );

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Fetch sequencer directly upstream of the 32-entry instruction ROM (5-bit address, enable, 32-bit combinational data out). It walks a program counter over the loaded program, drives the ROM address and enable, and captures each instruction into a one-entry output register. The register presents the instruction to the downstream decoder over a valid/ready handshake, with support for branch redirects and end-of-program halt.

## Interface
- PROG_LEN, 19: number of valid instructions at ROM addresses 0..PROG_LEN-1 (1..32).
- ADDR_W, 5: ROM address width.
- INSTR_W, 32: instruction width.

- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin fetching from address 0; honoured in IDLE and DONE only.
- rom_address  out  ADDR_W  ROM address; equals pc whenever rom_enable=1.
- rom_enable  out  1  ROM enable; high only in cycles that issue a fetch.
- rom_data  in  INSTR_W  ROM output, valid in the same cycle as rom_address.
- redirect_valid  in  1  branch/jump taken; load pc from redirect_addr.
- redirect_addr  in  ADDR_W  redirect target.
- out_instr  out  INSTR_W  buffered instruction.
- out_pc  out  ADDR_W  address out_instr was fetched from.
- out_valid  out  1  out_instr/out_pc valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- done  out  1  high in DONE once out_valid=0.

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state=IDLE, pc=0, out_valid=0, out_instr=0, out_pc=0, done=0, rom_enable=0, rom_address=0.
- IDLE: no fetches; start -> RUN with pc=0; redirect ignored.
- RUN fetch condition: (!out_valid || out_ready) && !redirect_valid. On fetch: rom_enable=1, rom_address=pc; at the edge, out_instr<=rom_data, out_pc<=pc, out_valid<=1, pc<=pc+1.
- Fetch with pc==PROG_LEN-1 -> DONE. pc never wraps; pc+1 is never issued after the last address.
- No fetch while out_valid && !out_ready: out_instr and out_pc hold stable, and rom_enable=0.
- An accept without a same-cycle fetch clears out_valid.
- Redirect in RUN or DONE has top priority. No fetch that cycle; out_valid<=0 (a same-cycle accept still counts as delivered). pc<=redirect_addr.
  - redirect_addr < PROG_LEN: state=RUN.
  - redirect_addr >= PROG_LEN: state=DONE.
- DONE: no fetches. The buffered instruction drains normally. done=1 when out_valid=0.
- start in DONE (no redirect): pc<=0, state=RUN. Any buffered instruction is kept and fetching resumes once it drains.
- start and redirect in the same cycle in DONE: redirect wins.
- reset mid-operation: all state returns to reset values next cycle, and the in-flight instruction is dropped.

## Timing
- start sampled at edge 0 -> RUN. Cycle 1 issues address 0; out_valid=1 from cycle 2.
- Fetch-to-output latency: 1 cycle.
- Throughput: 1 instruction per cycle while out_ready=1.
- Redirect sampled at edge k: out_valid=0 in cycle k+1 and target fetch issued in cycle k+1. Target instruction is valid in cycle k+2, a 1-bubble penalty.
- done rises the cycle after the final accept.
- rom_enable and rom_address are combinational from state, pc, out_valid and out_ready. All other outputs are registered.

## Structure
- Package instr_fetch_pkg:
  - state enum {IDLE, RUN, DONE};
  - ADDR_W and INSTR_W defaults;
  - PROG_LEN default 19.
- Sub-module fetch_out_reg: the one-entry valid/ready output register with flush input. Instantiated once.
- pc counter and FSM live in instr_fetch.

## Test plan
Bench ROM model returns rom_data = {27'h0, rom_address} + 32'h1000 when enabled.
- Stream: reset, start, out_ready=1.
  - Required: 19 accepts on consecutive cycles, out_pc 0..18, out_instr 32'h1000..32'h1012.
  - done=1 the cycle after out_pc=18 is accepted; no rom_enable after address 18.
- Backpressure: out_ready=0 for 4 cycles while out_pc=3.
  - Required: out_instr=32'h1003 stable and rom_enable=0 throughout.
  - On release, next accept is out_pc=4, with no skip and no duplicate.
- Redirect: redirect_valid=1, redirect_addr=10 while out_pc=5 is valid and accepted.
  - Required: one bubble, then out_pc 10,11,...
  - Address 6 is never delivered.
- Out-of-range redirect: redirect_addr=25 mid-run.
  - Required: out_valid=0 the next cycle, state DONE, done=1, and no further rom_enable.
- Reset mid-run at out_pc=7.
  - Required: next cycle out_valid=0, done=0, pc=0, IDLE, and no fetch until start.
- Restart: start asserted while in DONE.
  - Required: fetch resumes at address 0 and the full 19-instruction stream repeats.
